// File: rtl/serial_borrow_subtractor.sv
// Bit-serial subtractor: Y = A - B - Bin, LSB first, one registered borrow.
// Optional signed overflow flag V when SERIAL_SUB_OVERFLOW_EN is defined.
module serial_borrow_subtractor #(
   parameter int WIDTH = 4
) (
   input  logic             Clk,
   input  logic             Reset_n,
   input  logic             Start,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             Bin,
   output logic             Ready,
   output logic             Busy,
   output logic             Done,
   output logic [WIDTH-1:0] Y,
   output logic             Bout,
   output logic             V
);

   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DONE
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] a_sr;
   logic [WIDTH-1:0] b_sr;
   logic [WIDTH-1:0] r_sr;
   logic             brw;
   logic [CW-1:0]    cnt;

   logic             a_i;
   logic             b_i;
   logic             d;
   logic             brw_nxt;
   logic [WIDTH-1:0] r_nxt;
   logic             last;

`ifdef SERIAL_SUB_OVERFLOW_EN
   logic             a_msb;
   logic             b_msb;
`endif

   always_comb begin
      a_i     = a_sr[0];
      b_i     = b_sr[0];
      d       = a_i ^ b_i ^ brw;
      brw_nxt = (~a_i & b_i) | (~a_i & brw) | (b_i & brw);
      r_nxt   = {d, r_sr[WIDTH-1:1]};
      last    = (cnt == CW'(WIDTH - 1));
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state <= S_IDLE;
         Ready <= 1'b1;
         Busy  <= 1'b0;
         Done  <= 1'b0;
         Y     <= '0;
         Bout  <= 1'b0;
         a_sr  <= '0;
         b_sr  <= '0;
         r_sr  <= '0;
         brw   <= 1'b0;
         cnt   <= '0;
`ifdef SERIAL_SUB_OVERFLOW_EN
         V     <= 1'b0;
         a_msb <= 1'b0;
         b_msb <= 1'b0;
`endif
      end else begin
         unique case (state)
            S_IDLE: begin
               if (Start) begin
                  a_sr  <= A;
                  b_sr  <= B;
                  brw   <= Bin;
                  cnt   <= '0;
                  Ready <= 1'b0;
                  Busy  <= 1'b1;
                  state <= S_RUN;
`ifdef SERIAL_SUB_OVERFLOW_EN
                  a_msb <= A[WIDTH-1];
                  b_msb <= B[WIDTH-1];
`endif
               end
            end
            S_RUN: begin
               a_sr <= a_sr >> 1;
               b_sr <= b_sr >> 1;
               brw  <= brw_nxt;
               r_sr <= r_nxt;
               cnt  <= cnt + CW'(1);
               if (last) begin
                  // d is the result MSB on the final bit
                  Y     <= r_nxt;
                  Bout  <= brw_nxt;
                  Done  <= 1'b1;
                  Busy  <= 1'b0;
                  state <= S_DONE;
`ifdef SERIAL_SUB_OVERFLOW_EN
                  V     <= (a_msb ^ b_msb) & (a_msb ^ d);
`endif
               end
            end
            S_DONE: begin
               Done  <= 1'b0;
               Ready <= 1'b1;
               state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
               Ready <= 1'b1;
               Busy  <= 1'b0;
               Done  <= 1'b0;
            end
         endcase
      end
   end

`ifndef SERIAL_SUB_OVERFLOW_EN
   assign V = 1'b0;
`endif

endmodule

// File: tb/tb_serial_borrow_subtractor.sv
// Directed and random bench for serial_borrow_subtractor against an
// arithmetic reference model.
module tb_serial_borrow_subtractor;

   localparam int W = 4;

   logic         Clk;
   logic         Reset_n;
   logic         Start;
   logic [W-1:0] A;
   logic [W-1:0] B;
   logic         Bin;
   logic         Ready;
   logic         Busy;
   logic         Done;
   logic [W-1:0] Y;
   logic         Bout;
   logic         V;

   int n_chk  = 0;
   int n_fail = 0;

   logic [W-1:0] prev_y;
   logic         prev_b;
   logic         prev_v;

   serial_borrow_subtractor #(.WIDTH(W)) dut (
      .Clk    (Clk),
      .Reset_n(Reset_n),
      .Start  (Start),
      .A      (A),
      .B      (B),
      .Bin    (Bin),
      .Ready  (Ready),
      .Busy   (Busy),
      .Done   (Done),
      .Y      (Y),
      .Bout   (Bout),
      .V      (V)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_chk++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference: plain integer arithmetic, unsigned and signed views.
   task automatic model(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic bin, output logic [W-1:0] ey,
                        output logic eb, output logic ev);
      int du;
      int ds;
      du = int'(a) - int'(b) - int'(bin);
      ds = int'($signed(a)) - int'($signed(b)) - int'(bin);
      ey = W'(du);
      eb = (du < 0);
`ifdef SERIAL_SUB_OVERFLOW_EN
      ev = (ds > (2 ** (W - 1)) - 1) || (ds < -(2 ** (W - 1)));
`else
      ev = (ds > 1000000);
`endif
   endtask

   // Called at a negedge while idle. glitch>0 re-asserts Start
   // (with other operands) so that it is sampled at edge E0+glitch.
   task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic bin, input int glitch);
      logic [W-1:0] ey;
      logic         eb;
      logic         ev;
      int           k;
      model(a, b, bin, ey, eb, ev);
      chk("ready_pre", Ready, 1);
      A = a;
      B = b;
      Bin = bin;
      Start = 1'b1;
      @(posedge Clk);
      @(negedge Clk);
      Start = 1'b0;
      A = W'($urandom);
      B = W'($urandom);
      Bin = 1'($urandom);
      k = 0;
      while (!Done && k < W + 4) begin
         chk("busy_run", Busy, 1);
         chk("ready_run", Ready, 0);
         chk("y_hold", Y, prev_y);
         chk("bout_hold", Bout, prev_b);
         if (k + 1 == glitch) begin
            Start = 1'b1;
            A = 1;
            B = 1;
         end else begin
            Start = 1'b0;
         end
         @(posedge Clk);
         @(negedge Clk);
         k++;
      end
      Start = 1'b0;
      chk("latency", k, W);
      chk("done", Done, 1);
      chk("busy_done", Busy, 0);
      chk("ready_done", Ready, 0);
      chk("y", Y, ey);
      chk("bout", Bout, eb);
      chk("v", V, ev);
      @(posedge Clk);
      @(negedge Clk);
      chk("done_pulse", Done, 0);
      chk("ready_back", Ready, 1);
      chk("y_keep", Y, ey);
      prev_y = ey;
      prev_b = eb;
      prev_v = ev;
   endtask

   initial begin
      Reset_n = 1'b0;
      Start = 1'b0;
      A = '0;
      B = '0;
      Bin = 1'b0;
      prev_y = '0;
      prev_b = 1'b0;
      prev_v = 1'b0;
      repeat (2) @(negedge Clk);
      chk("rst_ready", Ready, 1);
      chk("rst_busy", Busy, 0);
      chk("rst_done", Done, 0);
      chk("rst_y", Y, 0);
      chk("rst_bout", Bout, 0);
      chk("rst_v", V, 0);
      Reset_n = 1'b1;
      @(negedge Clk);

      do_op(4'd5, 4'd3, 1'b0, 0);
      do_op(4'd3, 4'd5, 1'b0, 0);
      do_op(4'd0, 4'd0, 1'b1, 0);
      do_op(4'd9, 4'd9, 1'b0, 0);
      do_op(4'd8, 4'd1, 1'b0, 0);
      do_op(4'd4, 4'd12, 1'b0, 0);

      // Start during RUN must be ignored, only one result/pulse
      do_op(4'd7, 4'd2, 1'b0, 2);
      repeat (3) begin
         chk("no_restart", Ready, 1);
         chk("no_extra_done", Done, 0);
         chk("y_after_ign", Y, 4'd5);
         @(negedge Clk);
      end

      // Reset mid-operation aborts with no Done
      A = 4'd12;
      B = 4'd4;
      Bin = 1'b0;
      Start = 1'b1;
      @(posedge Clk);
      @(negedge Clk);
      Start = 1'b0;
      @(posedge Clk);
      @(posedge Clk);
      #1 Reset_n = 1'b0;
      #1;
      chk("abort_ready", Ready, 1);
      chk("abort_busy", Busy, 0);
      chk("abort_done", Done, 0);
      chk("abort_y", Y, 0);
      chk("abort_bout", Bout, 0);
      chk("abort_v", V, 0);
      @(negedge Clk);
      @(negedge Clk);
      Reset_n = 1'b1;
      prev_y = '0;
      prev_b = 1'b0;
      prev_v = 1'b0;
      repeat (W + 2) begin
         chk("abort_nodone", Done, 0);
         chk("abort_idle", Ready, 1);
         @(negedge Clk);
      end
      do_op(4'd12, 4'd4, 1'b0, 0);

      for (int i = 0; i < 40; i++) begin
         do_op(W'($urandom), W'($urandom), 1'($urandom), 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
